// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the MEM-stage LSU (master) and the data memory (slave).
// The request fields stay stable from dmem_req rising until the cycle dmem_ack is seen.
interface mem_stage_lsu_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// MIPS MEM-stage load/store unit: one req/ack data-memory transaction per instruction,
// byte/half/word alignment, EX/MEM stall generation and registered MEM/WB results.
module mem_stage_lsu #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [31:0]     in_addr,
    input  logic [31:0]     in_wdata,
    input  logic            in_mem_rd,
    input  logic            in_mem_wr,
    input  logic [1:0]      in_size,
    input  logic            in_ld_unsigned,
    input  logic [4:0]      in_rd,
    input  logic            in_regwrite,
    output logic            stall,
    mem_stage_lsu_if.master dmem,
    output logic            wb_valid,
    output logic [31:0]     wb_data,
    output logic [4:0]      wb_rd,
    output logic            wb_regwrite,
    output logic            misalign_err,
    output logic            bus_err
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              req_reg, req_next;
    logic              we_reg, we_next;
    logic [31:0]       addr_reg, addr_next;
    logic [3:0]        be_reg, be_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic              wb_valid_reg, wb_valid_next;
    logic [31:0]       wb_data_reg, wb_data_next;
    logic [4:0]        wb_rd_reg, wb_rd_next;
    logic              wb_regwrite_reg, wb_regwrite_next;
    logic              misalign_reg, misalign_next;
    logic              bus_err_reg, bus_err_next;

    logic              mem_op;
    logic              misaligned;
    logic              timeout_hit;
    logic              stall_c;
    logic [3:0]        be_c;
    logic [31:0]       wdata_c;
    logic [31:0]       lane_c;
    logic [31:0]       load_c;
    logic [31:0]       rd_shift [4];

    assign mem_op      = in_valid & (in_mem_rd | in_mem_wr);
    assign misaligned  = (in_size == 2'b11)
                       | ((in_size == 2'b01) & in_addr[0])
                       | ((in_size == 2'b10) & (in_addr[1:0] != 2'b00));
    assign timeout_hit = (cnt_reg == CNT_LAST);

    // Read data shifted down so the addressed byte sits in bits [7:0].
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign rd_shift[gi] = dmem.dmem_rdata >> (8 * gi);
    end
    assign lane_c = rd_shift[in_addr[1:0]];

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = in_wdata;
        load_c  = lane_c;
        case (in_size)
            2'b00: begin
                be_c    = 4'b0001 << in_addr[1:0];
                wdata_c = {4{in_wdata[7:0]}};
                load_c  = {{24{~in_ld_unsigned & lane_c[7]}}, lane_c[7:0]};
            end
            2'b01: begin
                be_c    = 4'b0011 << in_addr[1:0];
                wdata_c = {2{in_wdata[15:0]}};
                load_c  = {{16{~in_ld_unsigned & lane_c[15]}}, lane_c[15:0]};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        req_next         = req_reg;
        we_next          = we_reg;
        addr_next        = addr_reg;
        be_next          = be_reg;
        wdata_next       = wdata_reg;
        wb_valid_next    = 1'b0;
        wb_data_next     = wb_data_reg;
        wb_rd_next       = wb_rd_reg;
        wb_regwrite_next = wb_regwrite_reg;
        misalign_next    = 1'b0;
        bus_err_next     = 1'b0;
        stall_c          = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (mem_op && !misaligned) begin
                    stall_c    = 1'b1;
                    state_next = ST_WAIT;
                    cnt_next   = '0;
                    req_next   = 1'b1;
                    we_next    = in_mem_wr;
                    addr_next  = {in_addr[31:2], 2'b00};
                    be_next    = be_c;
                    wdata_next = wdata_c;
                end else if (mem_op) begin
                    wb_valid_next    = 1'b1;
                    wb_data_next     = in_addr;
                    wb_rd_next       = in_rd;
                    wb_regwrite_next = 1'b0;
                    misalign_next    = 1'b1;
                end else if (in_valid) begin
                    wb_valid_next    = 1'b1;
                    wb_data_next     = in_addr;
                    wb_rd_next       = in_rd;
                    wb_regwrite_next = in_regwrite;
                end else begin
                    wb_regwrite_next = 1'b0;
                end
            end
            ST_WAIT: begin
                // EX/MEM is held while stalled, so in_* still describe this access.
                if (dmem.dmem_ack) begin
                    state_next       = ST_IDLE;
                    req_next         = 1'b0;
                    wb_valid_next    = 1'b1;
                    wb_data_next     = we_reg ? in_addr : load_c;
                    wb_rd_next       = in_rd;
                    wb_regwrite_next = we_reg ? 1'b0 : in_regwrite;
                end else if (timeout_hit) begin
                    state_next       = ST_IDLE;
                    req_next         = 1'b0;
                    wb_valid_next    = 1'b1;
                    wb_data_next     = in_addr;
                    wb_rd_next       = in_rd;
                    wb_regwrite_next = 1'b0;
                    bus_err_next     = 1'b1;
                end else begin
                    stall_c  = 1'b1;
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            req_reg         <= 1'b0;
            we_reg          <= 1'b0;
            addr_reg        <= '0;
            be_reg          <= '0;
            wdata_reg       <= '0;
            wb_valid_reg    <= 1'b0;
            wb_data_reg     <= '0;
            wb_rd_reg       <= '0;
            wb_regwrite_reg <= 1'b0;
            misalign_reg    <= 1'b0;
            bus_err_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            req_reg         <= req_next;
            we_reg          <= we_next;
            addr_reg        <= addr_next;
            be_reg          <= be_next;
            wdata_reg       <= wdata_next;
            wb_valid_reg    <= wb_valid_next;
            wb_data_reg     <= wb_data_next;
            wb_rd_reg       <= wb_rd_next;
            wb_regwrite_reg <= wb_regwrite_next;
            misalign_reg    <= misalign_next;
            bus_err_reg     <= bus_err_next;
        end
    end

    // Stall is combinational, so it is gated by reset to fall immediately.
    assign stall           = rst & stall_c;
    assign dmem.dmem_req   = req_reg;
    assign dmem.dmem_we    = we_reg;
    assign dmem.dmem_addr  = addr_reg;
    assign dmem.dmem_be    = be_reg;
    assign dmem.dmem_wdata = wdata_reg;
    assign wb_valid        = wb_valid_reg;
    assign wb_data         = wb_data_reg;
    assign wb_rd           = wb_rd_reg;
    assign wb_regwrite     = wb_regwrite_reg;
    assign misalign_err    = misalign_reg;
    assign bus_err         = bus_err_reg;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a memory responder with per-instruction ack delay,
// a behavioural expectation model, and a per-cycle MEM/WB compare process.
module tb_mem_stage_lsu;
    localparam int T = 16;

    typedef struct {
        logic        rd_op;
        logic        wr_op;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic [4:0]  rd;
        logic        regw;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        regw;
        logic        mis;
        logic        berr;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          stalls;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_addr = '0;
    logic [31:0] in_wdata = '0;
    logic        in_mem_rd = 1'b0;
    logic        in_mem_wr = 1'b0;
    logic [1:0]  in_size = '0;
    logic        in_ld_unsigned = 1'b0;
    logic [4:0]  in_rd = '0;
    logic        in_regwrite = 1'b0;
    logic        stall;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic        misalign_err;
    logic        bus_err;

    int          checks = 0;
    int          failures = 0;
    exp_t        exp_q[$];
    exp_t        cur_exp;
    exp_t        ce;
    exp_t        pin;
    logic [31:0] rsp_rdata = '0;
    int          rsp_delay = 0;
    int          req_cyc = 0;
    vec_t        vecs[$];
    vec_t        v;

    mem_stage_lsu_if bus ();

    mem_stage_lsu #(.TIMEOUT_CYC(T)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_addr        (in_addr),
        .in_wdata       (in_wdata),
        .in_mem_rd      (in_mem_rd),
        .in_mem_wr      (in_mem_wr),
        .in_size        (in_size),
        .in_ld_unsigned (in_ld_unsigned),
        .in_rd          (in_rd),
        .in_regwrite    (in_regwrite),
        .stall          (stall),
        .dmem           (bus),
        .wb_valid       (wb_valid),
        .wb_data        (wb_data),
        .wb_rd          (wb_rd),
        .wb_regwrite    (wb_regwrite),
        .misalign_err   (misalign_err),
        .bus_err        (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic rdop, input logic wrop, input logic [1:0] sz,
                                 input logic uns, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rdv, input int dly, input logic [4:0] rd,
                                 input logic regw);
        vec_t r;
        r.rd_op = rdop; r.wr_op = wrop; r.size = sz; r.uns = uns; r.addr = a;
        r.wdata = wd; r.rdata = rdv; r.delay = dly; r.rd = rd; r.regw = regw;
        return r;
    endfunction

    // Expected outcome of one instruction, from the access-size arithmetic.
    function automatic exp_t model(input vec_t x);
        exp_t        e;
        int          nb;
        int          off;
        logic [7:0]  bb;
        logic [63:0] mask;
        logic [63:0] val;
        e = '{default: 0};
        nb  = (x.size == 2'd0) ? 1 : (x.size == 2'd1) ? 2 : 4;
        off = int'(x.addr % 32'd4);
        e.rd = x.rd;
        e.data = x.addr;
        if (!(x.rd_op || x.wr_op)) begin
            e.regw = x.regw;
            return e;
        end
        if (x.size == 2'd3 || (off % nb) != 0) begin
            e.mis = 1'b1;
            return e;
        end
        e.req  = 1'b1;
        e.we   = x.wr_op;
        e.addr = x.addr - 32'(off);
        bb     = 8'((1 << nb) - 1) << off;
        e.be   = bb[3:0];
        for (int k = 0; k < 4; k++) e.wdata[8*k +: 8] = x.wdata[8*(k % nb) +: 8];
        if (x.delay >= T) begin
            e.berr   = 1'b1;
            e.stalls = T;
            return e;
        end
        e.stalls = 1 + x.delay;
        if (x.wr_op) return e;
        mask = (64'd1 << (8 * nb)) - 64'd1;
        val  = ({32'd0, x.rdata} >> (8 * off)) & mask;
        if (!x.uns && val[8*nb-1]) val = val | ~mask;
        e.data = val[31:0];
        e.regw = x.regw;
        return e;
    endfunction

    task automatic drive(input vec_t x);
        in_valid = 1'b1; in_addr = x.addr; in_wdata = x.wdata;
        in_mem_rd = x.rd_op; in_mem_wr = x.wr_op; in_size = x.size;
        in_ld_unsigned = x.uns; in_rd = x.rd; in_regwrite = x.regw;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_mem_rd = 1'b0; in_mem_wr = 1'b0;
    endtask

    // Call at posedge+1; returns at posedge+1 after the instruction is accepted.
    task automatic issue(input vec_t x);
        exp_t e;
        int   n;
        bit   done;
        e = model(x);
        cur_exp = e;
        rsp_rdata = x.rdata;
        rsp_delay = x.delay;
        exp_q.push_back(e);
        drive(x);
        n = 0;
        done = 0;
        while (!done && n < 64) begin
            @(negedge clk);
            if (!stall) done = 1;
            else n++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL stall_bound: stall still high after %0d cycles, addr 0x%08h", n, x.addr);
        end
        chk("stall_cycles", n, e.stalls);
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    // Data memory: acks on the (delay+1)-th request cycle and checks request fields each cycle.
    initial begin
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = 32'h5A5A5A5A;
        forever begin
            @(posedge clk);
            #1;
            if (!rst || !bus.dmem_req) begin
                req_cyc = 0;
                bus.dmem_ack = 1'b0;
                bus.dmem_rdata = 32'h5A5A5A5A;
            end else begin
                req_cyc++;
                chk("req_expected", 32'(bus.dmem_req), 32'(cur_exp.req));
                chk("req_we", 32'(bus.dmem_we), 32'(cur_exp.we));
                chk("req_addr", bus.dmem_addr, cur_exp.addr);
                chk("req_be", 32'(bus.dmem_be), 32'(cur_exp.be));
                if (cur_exp.we) chk("req_wdata", bus.dmem_wdata, cur_exp.wdata);
                if (req_cyc == rsp_delay + 1) begin
                    bus.dmem_ack = 1'b1;
                    bus.dmem_rdata = rsp_rdata;
                end else begin
                    bus.dmem_ack = 1'b0;
                    bus.dmem_rdata = 32'h5A5A5A5A;
                end
            end
        end
    end

    // MEM/WB compare on every cycle out of reset.
    always @(negedge clk) begin
        if (rst) begin
            if (wb_valid) begin
                if (exp_q.size() == 0) begin
                    chk("wb_spurious_valid", 32'(wb_valid), 32'd0);
                end else begin
                    ce = exp_q.pop_front();
                    $display("wb rd=%0d data=0x%08h regw=%0b mis=%0b berr=%0b",
                             wb_rd, wb_data, wb_regwrite, misalign_err, bus_err);
                    chk("wb_regwrite", 32'(wb_regwrite), 32'(ce.regw));
                    chk("wb_misalign_err", 32'(misalign_err), 32'(ce.mis));
                    chk("wb_bus_err", 32'(bus_err), 32'(ce.berr));
                    if (!ce.mis && !ce.berr) begin
                        chk("wb_data", wb_data, ce.data);
                        chk("wb_rd", 32'(wb_rd), 32'(ce.rd));
                    end
                end
            end else begin
                chk("err_without_valid", 32'({misalign_err, bus_err}), 32'd0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Hand-computed pins on the model itself.
        pin = model(mkv(1, 0, 2'd2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 3, 5'd2, 1));
        chk("pin_lw_data", pin.data, 32'hDEADBEEF);
        chk("pin_lw_stalls", pin.stalls, 4);
        pin = model(mkv(1, 0, 2'd0, 0, 32'h103, 32'h0, 32'h80000000, 0, 5'd3, 1));
        chk("pin_lb_data", pin.data, 32'hFFFFFF80);
        pin = model(mkv(1, 0, 2'd0, 1, 32'h103, 32'h0, 32'h80000000, 0, 5'd3, 1));
        chk("pin_lbu_data", pin.data, 32'h00000080);
        pin = model(mkv(0, 1, 2'd1, 0, 32'h202, 32'h1234ABCD, 32'h0, 0, 5'd0, 1));
        chk("pin_sh_be", 32'(pin.be), 32'b1100);
        chk("pin_sh_wdata", pin.wdata, 32'hABCDABCD);
        chk("pin_sh_regw", 32'(pin.regw), 32'd0);
        pin = model(mkv(1, 0, 2'd2, 0, 32'h101, 32'h0, 32'h0, 0, 5'd5, 1));
        chk("pin_misalign", 32'({pin.mis, pin.req}), 32'b10);
        pin = model(mkv(0, 1, 2'd2, 0, 32'h300, 32'h0, 32'h0, 99, 5'd0, 0));
        chk("pin_timeout", 32'(pin.berr), 32'd1);
        chk("pin_timeout_stalls", pin.stalls, T);

        // Reset: an aligned load presented during reset must not raise stall.
        drive(mkv(1, 0, 2'd2, 0, 32'h100, 32'h0, 32'h0, 0, 5'd1, 1));
        repeat (2) @(posedge clk);
        #2;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(bus.dmem_req), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_rd_regw", 32'({wb_rd, wb_regwrite}), 32'd0);
        chk("rst_errs", 32'({misalign_err, bus_err}), 32'd0);
        chk("rst_bus_out", 32'({bus.dmem_we, bus.dmem_be}), 32'd0);
        chk("rst_bus_addr", bus.dmem_addr | bus.dmem_wdata, 32'd0);
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        vecs.push_back(mkv(1, 0, 2'd2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 3, 5'd2, 1));
        vecs.push_back(mkv(1, 0, 2'd0, 0, 32'h103, 32'h0, 32'h80000000, 0, 5'd3, 1));
        vecs.push_back(mkv(1, 0, 2'd0, 1, 32'h103, 32'h0, 32'h80000000, 1, 5'd4, 1));
        vecs.push_back(mkv(0, 1, 2'd1, 0, 32'h202, 32'h1234ABCD, 32'h0, 0, 5'd6, 1));
        vecs.push_back(mkv(1, 0, 2'd2, 0, 32'h101, 32'h0, 32'h0, 0, 5'd5, 1));
        vecs.push_back(mkv(0, 1, 2'd2, 0, 32'h300, 32'hCAFEF00D, 32'h0, 99, 5'd9, 1));
        vecs.push_back(mkv(0, 0, 2'd2, 0, 32'h12345678, 32'h0, 32'h0, 0, 5'd7, 1));
        vecs.push_back(mkv(1, 0, 2'd1, 0, 32'h0FE, 32'h0, 32'h80017F00, 2, 5'd8, 1));
        vecs.push_back(mkv(1, 0, 2'd1, 1, 32'h0FE, 32'h0, 32'h80017F00, 0, 5'd10, 1));
        vecs.push_back(mkv(0, 1, 2'd0, 0, 32'h301, 32'h000000A5, 32'h0, 0, 5'd11, 1));
        vecs.push_back(mkv(1, 0, 2'd3, 0, 32'h104, 32'h0, 32'h0, 0, 5'd12, 1));
        vecs.push_back(mkv(1, 0, 2'd1, 0, 32'h103, 32'h0, 32'h0, 0, 5'd13, 1));
        vecs.push_back(mkv(1, 1, 2'd2, 0, 32'h208, 32'h11223344, 32'h99999999, 1, 5'd14, 1));
        vecs.push_back(mkv(1, 0, 2'd2, 0, 32'h20C, 32'h0, 32'h0BADF00D, T - 1, 5'd15, 1));
        vecs.push_back(mkv(1, 0, 2'd2, 0, 32'h210, 32'h0, 32'h0BADF00D, T, 5'd16, 1));
        vecs.push_back(mkv(1, 0, 2'd0, 0, 32'h101, 32'h0, 32'h1234FF56, 0, 5'd17, 1));
        vecs.push_back(mkv(1, 0, 2'd0, 1, 32'h101, 32'h0, 32'h1234FF56, 2, 5'd18, 1));
        vecs.push_back(mkv(1, 0, 2'd2, 0, 32'h004, 32'h0, 32'h00000077, 0, 5'd19, 0));
        vecs.push_back(mkv(0, 0, 2'd0, 0, 32'hFFFFFFFC, 32'h0, 32'h0, 0, 5'd31, 0));

        foreach (vecs[i]) begin
            issue(vecs[i]);
            if (i % 4 == 3) begin
                repeat (2) @(posedge clk);
                #1;
            end
        end

        // Asynchronous reset in the middle of a WAIT.
        v = mkv(1, 0, 2'd2, 0, 32'h400, 32'h0, 32'h0, 99, 5'd20, 1);
        cur_exp = model(v);
        rsp_delay = 99;
        drive(v);
        repeat (3) @(posedge clk);
        #3;
        chk("pre_rst_stall", 32'(stall), 32'd1);
        chk("pre_rst_req", 32'(bus.dmem_req), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_req", 32'(bus.dmem_req), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_wb_valid", 32'(wb_valid), 32'd0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        issue(mkv(1, 0, 2'd2, 0, 32'h404, 32'h0, 32'h13579BDF, 1, 5'd21, 1));

        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
